ntsc_sync_gen: RTL and testbench

NTSC raster timing and colour-subcarrier phase generator. Runs on the 4×fsc clock (14.31818 MHz) and drives the composite encoder that follows it with subcarrier phase (`O_SC`), pixel-clock enable, horizontal and vertical sync, and display enable. Horizontal and vertical counters are built in. All outputs are registered and mutually aligned, so the encoder needs no local realignment.

---
 rtl/ntsc_sync_gen.sv | 105 ++++++++++
 tb/tb_ntsc_sync_gen.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ntsc_sync_gen.sv
// NTSC raster timing + 4xfsc subcarrier phase; NTSC_SC_FRAME_RESYNC_EN reloads sc=0 at every frame start.
// Latency: every output at edge t+1 decodes the counter state present at edge t (one register stage).
// Backpressure: none; the block free-runs and never stalls.
module ntsc_sync_gen #(
    parameter int H_TOTAL      = 910,
    parameter int H_SYNC       = 67,
    parameter int H_DISP_START = 160,
    parameter int H_DISP_LEN   = 640,
    parameter int V_TOTAL      = 262,
    parameter int V_SYNC       = 3,
    parameter int V_DISP_START = 40,
    parameter int V_DISP_LEN   = 200,
    parameter int ICLK_DIV     = 2
) (
    input  logic       I_CLK,
    input  logic       I_RESET_n,
    output logic [1:0] O_SC,
    output logic       O_ICLK_EN,
    output logic       O_HSYNC,
    output logic       O_VSYNC,
    output logic       O_DISP,
    output logic       O_FSTART,
    output logic [9:0] O_HCNT,
    output logic [8:0] O_VCNT
);

    localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [8:0]  V_LAST    = 9'(V_TOTAL - 1);
    localparam logic [10:0] H_SYNC_W  = 11'(H_SYNC);
    localparam logic [10:0] H_DS      = 11'(H_DISP_START);
    localparam logic [10:0] H_DE      = 11'(H_DISP_START + H_DISP_LEN);
    localparam logic [9:0]  V_SYNC_W  = 10'(V_SYNC);
    localparam logic [9:0]  V_DS      = 10'(V_DISP_START);
    localparam logic [9:0]  V_DE      = 10'(V_DISP_START + V_DISP_LEN);
    // ICLK_DIV is restricted to 1/2/4, so the modulo reduces to a mask
    localparam logic [9:0]  ICLK_MASK = 10'(ICLK_DIV - 1);

    logic [9:0] hcnt;
    logic [8:0] vcnt;
    logic [1:0] sc;
    logic       h_wrap;
    logic       v_wrap;

    logic       hsync_d;
    logic       vsync_d;
    logic       disp_d;
    logic       iclk_d;
    logic       fstart_d;

    assign h_wrap = (hcnt == H_LAST);
    assign v_wrap = (vcnt == V_LAST);

    always_ff @(posedge I_CLK or negedge I_RESET_n) begin
        if (!I_RESET_n) begin
            hcnt <= '0;
            vcnt <= '0;
            sc   <= '0;
        end else begin
            if (h_wrap) begin
                hcnt <= '0;
                vcnt <= v_wrap ? 9'd0 : vcnt + 9'd1;
            end else begin
                hcnt <= hcnt + 10'd1;
            end
`ifdef NTSC_SC_FRAME_RESYNC_EN
            sc <= (h_wrap && v_wrap) ? 2'd0 : sc + 2'd1;
`else
            sc <= sc + 2'd1;
`endif
        end
    end

    // Window compares carry one extra bit so START+LEN cannot overflow
    always_comb begin
        hsync_d  = ({1'b0, hcnt} < H_SYNC_W);
        vsync_d  = ({1'b0, vcnt} < V_SYNC_W);
        disp_d   = ({1'b0, hcnt} >= H_DS) && ({1'b0, hcnt} < H_DE) &&
                   ({1'b0, vcnt} >= V_DS) && ({1'b0, vcnt} < V_DE);
        iclk_d   = ((hcnt & ICLK_MASK) == ICLK_MASK);
        fstart_d = (hcnt == 10'd0) && (vcnt == 9'd0);
    end

    always_ff @(posedge I_CLK or negedge I_RESET_n) begin
        if (!I_RESET_n) begin
            O_SC      <= '0;
            O_ICLK_EN <= 1'b0;
            O_HSYNC   <= 1'b0;
            O_VSYNC   <= 1'b0;
            O_DISP    <= 1'b0;
            O_FSTART  <= 1'b0;
            O_HCNT    <= '0;
            O_VCNT    <= '0;
        end else begin
            O_SC      <= sc;
            O_ICLK_EN <= iclk_d;
            O_HSYNC   <= hsync_d;
            O_VSYNC   <= vsync_d;
            O_DISP    <= disp_d;
            O_FSTART  <= fstart_d;
            O_HCNT    <= hcnt;
            O_VCNT    <= vcnt;
        end
    end

endmodule

// File: tb/tb_ntsc_sync_gen.sv
// Scoreboard bench: three parameterisations share one clock/reset; expectations come from
// an arithmetic model indexed by clocks elapsed since reset release.
module tb_ntsc_sync_gen;

    typedef struct packed {
        logic [1:0] sc;
        logic       ic;
        logic       hs;
        logic       vs;
        logic       dp;
        logic       fs;
        logic [9:0] h;
        logic [8:0] v;
    } exp_t;

    typedef struct packed {
        int   k;
        exp_t a;
        exp_t b;
        exp_t c;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] a_sc, b_sc, c_sc;
    logic       a_ic, a_hs, a_vs, a_dp, a_fs;
    logic       b_ic, b_hs, b_vs, b_dp, b_fs;
    logic       c_ic, c_hs, c_vs, c_dp, c_fs;
    logic [9:0] a_h, b_h, c_h;
    logic [8:0] a_v, b_v, c_v;

    // Default NTSC timing
    ntsc_sync_gen dut_a (
        .I_CLK(clk), .I_RESET_n(rst_n), .O_SC(a_sc), .O_ICLK_EN(a_ic),
        .O_HSYNC(a_hs), .O_VSYNC(a_vs), .O_DISP(a_dp), .O_FSTART(a_fs),
        .O_HCNT(a_h), .O_VCNT(a_v)
    );

    // Tiny raster, frame length 266 = 2 mod 4, so many frames fit in the run
    ntsc_sync_gen #(
        .H_TOTAL(38), .H_SYNC(5), .H_DISP_START(8), .H_DISP_LEN(24),
        .V_TOTAL(7), .V_SYNC(2), .V_DISP_START(2), .V_DISP_LEN(4), .ICLK_DIV(2)
    ) dut_b (
        .I_CLK(clk), .I_RESET_n(rst_n), .O_SC(b_sc), .O_ICLK_EN(b_ic),
        .O_HSYNC(b_hs), .O_VSYNC(b_vs), .O_DISP(b_dp), .O_FSTART(b_fs),
        .O_HCNT(b_h), .O_VCNT(b_v)
    );

    ntsc_sync_gen #(.H_TOTAL(912), .ICLK_DIV(4)) dut_c (
        .I_CLK(clk), .I_RESET_n(rst_n), .O_SC(c_sc), .O_ICLK_EN(c_ic),
        .O_HSYNC(c_hs), .O_VSYNC(c_vs), .O_DISP(c_dp), .O_FSTART(c_fs),
        .O_HCNT(c_h), .O_VCNT(c_v)
    );

    exp_t act_a, act_b, act_c;
    assign act_a = {a_sc, a_ic, a_hs, a_vs, a_dp, a_fs, a_h, a_v};
    assign act_b = {b_sc, b_ic, b_hs, b_vs, b_dp, b_fs, b_h, b_v};
    assign act_c = {c_sc, c_ic, c_hs, c_vs, c_dp, c_fs, c_h, c_v};

    sb_t sbq[$];
    int  n_cmp  = 0;
    int  n_fail = 0;
    int  kk     = 0;
    logic prev_r = 1'b0;

    // Output seen k clocks after the first post-release edge, from raster arithmetic
    function automatic exp_t model(input int k, input int ht, input int hsw, input int hds,
                                   input int hdl, input int vt, input int vsw, input int vds,
                                   input int vdl, input int div);
        exp_t e;
        int h, v, f;
        h = k % ht;
        v = (k / ht) % vt;
        f = k % (ht * vt);
`ifdef NTSC_SC_FRAME_RESYNC_EN
        e.sc = 2'(f % 4);
`else
        e.sc = 2'(k % 4);
`endif
        e.ic = ((h % div) == div - 1);
        e.hs = (h < hsw);
        e.vs = (v < vsw);
        e.dp = (h >= hds) && (h < hds + hdl) && (v >= vds) && (v < vds + vdl);
        e.fs = (f == 0);
        e.h  = 10'(h);
        e.v  = 9'(v);
        return e;
    endfunction

    task automatic check(input string name, input exp_t act, input exp_t exp, input int k);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s k=%0d: got sc=%0d ic=%b hs=%b vs=%b dp=%b fs=%b h=%0d v=%0d, want sc=%0d ic=%b hs=%b vs=%b dp=%b fs=%b h=%0d v=%0d",
                     name, k, act.sc, act.ic, act.hs, act.vs, act.dp, act.fs, act.h, act.v,
                     exp.sc, exp.ic, exp.hs, exp.vs, exp.dp, exp.fs, exp.h, exp.v);
        end
    endtask

    // One clock: note what the edge produced, then drive reset value r at +2
    task automatic cycle(input logic r);
        sb_t e;
        int  used;
        @(posedge clk);
        used = kk;
        if (prev_r) kk++;
        #2;
        rst_n = r;
        e.k = used;
        if (r && prev_r) begin
            e.a = model(used, 910, 67, 160, 640, 262, 3, 40, 200, 2);
            e.b = model(used, 38, 5, 8, 24, 7, 2, 2, 4, 2);
            e.c = model(used, 912, 67, 160, 640, 262, 3, 40, 200, 4);
        end else begin
            e.a = '0;
            e.b = '0;
            e.c = '0;
        end
        if (!r) kk = 0;
        sbq.push_back(e);
        prev_r = r;
    endtask

    task automatic run(input int n);
        repeat (n) cycle(1'b1);
    endtask

    task automatic hold_reset(input int n);
        repeat (n) cycle(1'b0);
    endtask

    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("dut_default", act_a, e.a, e.k);
                check("dut_small",   act_b, e.b, e.k);
                check("dut_div4",    act_c, e.c, e.k);
            end
        end
    end

    initial begin
        hold_reset(3);
        // Reset lands mid-line (hcnt 500 of line 10) and must clear outputs without a clock
        run(10 * 910 + 501);
        hold_reset($urandom_range(5, 1));
        // Long run reaches line 40 (display start) including line 39
        run(41000);
        for (int i = 0; i < 4; i++) begin
            hold_reset($urandom_range(4, 1));
            run($urandom_range(3000, 300));
        end
        repeat (2) @(posedge clk);
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
